// File: rtl/spi_transaction_queue.sv
// Command-buffering sequencer in front of spi_master: a small command FIFO feeds
// one SPI transfer at a time, read responses are held for a consumer, and frames are spaced by a gap.
module spi_transaction_queue #(
  parameter int SPI_DATA_WIDTH    = 32,
  parameter int FIFO_ADDR_WIDTH   = 2,
  parameter int GAP_COUNTER_WIDTH = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [GAP_COUNTER_WIDTH-1:0] i_gap_cycles,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [SPI_DATA_WIDTH-1:0]    i_cmd_data,
  input  logic                         i_cmd_read,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [SPI_DATA_WIDTH-1:0]    o_rsp_data,
  output logic                         o_spi_enable,
  output logic [SPI_DATA_WIDTH-1:0]    o_spi_data,
  input  logic [SPI_DATA_WIDTH-1:0]    i_spi_data,
  input  logic                         i_spi_done,
  input  logic                         i_spi_busy,
  output logic [FIFO_ADDR_WIDTH:0]     o_cmd_count,
  output logic                         o_idle
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0]     CNT_FULL = (FIFO_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0]     CNT_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0]   PTR_ONE  = FIFO_ADDR_WIDTH'(1);
  localparam logic [GAP_COUNTER_WIDTH-1:0] GAP_ONE  = GAP_COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT_DONE, ST_GAP} state_t;

  state_t                         r_state;
  logic [SPI_DATA_WIDTH:0]        r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]     r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0]     r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]       r_count;
  logic                           r_read_flag;
  logic                           r_spi_enable;
  logic [SPI_DATA_WIDTH-1:0]      r_spi_data;
  logic                           r_rsp_valid;
  logic [SPI_DATA_WIDTH-1:0]      r_rsp_data;
  logic [GAP_COUNTER_WIDTH-1:0]   r_gap_count;

  logic                           w_full;
  logic                           w_empty;
  logic                           w_push;
  logic                           w_pop;
  logic [SPI_DATA_WIDTH:0]        w_head;
  logic                           w_head_read;
  logic [SPI_DATA_WIDTH-1:0]      w_head_data;
  logic                           w_launch;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign o_cmd_ready = !w_full && !i_reset;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == ST_LAUNCH);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_read = w_head[SPI_DATA_WIDTH];
  assign w_head_data = w_head[SPI_DATA_WIDTH-1:0];

  // A read may only start when the response register is free, so a load never meets a drain.
  assign w_launch = (r_state == ST_IDLE) && !w_empty && !i_spi_busy &&
                    (!w_head_read || !r_rsp_valid);

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd_read, i_cmd_data};
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_spi_enable <= 1'b0;
      r_spi_data   <= '0;
      r_read_flag  <= 1'b0;
      r_gap_count  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      r_spi_enable <= 1'b0;
      if (r_rsp_valid && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state      <= ST_LAUNCH;
            r_spi_enable <= 1'b1;
            r_spi_data   <= w_head_data;
            r_read_flag  <= w_head_read;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_spi_done) begin
            if (r_read_flag) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= i_spi_data;
            end
            r_gap_count <= i_gap_cycles;
            r_state     <= (i_gap_cycles == '0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          r_gap_count <= r_gap_count - GAP_ONE;
          if (r_gap_count == GAP_ONE) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_enable = r_spi_enable;
  assign o_spi_data   = r_spi_data;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_cmd_count  = r_count;
  assign o_idle       = (r_state == ST_IDLE) && w_empty;

endmodule

// File: tb/tb_spi_transaction_queue.sv
// Directed bench for spi_transaction_queue with a behavioural spi_master stand-in
// that records every launch and completion.
module tb_spi_transaction_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gap_cycles;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        cmd_read;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        spi_enable;
  logic [31:0] spi_mosi;
  logic [31:0] spi_miso;
  logic        spi_done;
  logic        spi_busy;
  logic [2:0]  cmd_count;
  logic        idle;

  logic        m_busy;
  logic        m_hold;
  logic        force_busy;
  int          m_cnt;
  int          m_lat;
  int          ncyc;
  logic [31:0] miso_q[$];
  logic [31:0] launch_q[$];
  int          launch_t[$];
  int          done_t[$];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign spi_busy = m_busy | force_busy;

  spi_transaction_queue dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_gap_cycles (gap_cycles),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_data   (cmd_data),
    .i_cmd_read   (cmd_read),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_spi_enable (spi_enable),
    .o_spi_data   (spi_mosi),
    .i_spi_data   (spi_miso),
    .i_spi_done   (spi_done),
    .i_spi_busy   (spi_busy),
    .o_cmd_count  (cmd_count),
    .o_idle       (idle)
  );

  // spi_master stand-in: busy from the enable pulse until a one-cycle done after m_lat cycles.
  initial begin
    m_busy   = 1'b0;
    spi_done = 1'b0;
    spi_miso = '0;
    m_cnt    = 0;
    ncyc     = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      spi_done = 1'b0;
      if (spi_enable) begin
        m_busy = 1'b1;
        m_cnt  = m_lat;
        launch_q.push_back(spi_mosi);
        launch_t.push_back(ncyc);
        $display("[%0d] launch mosi=%08h", ncyc, spi_mosi);
      end else if (m_busy && !m_hold) begin
        if (m_cnt == 0) begin
          spi_done = 1'b1;
          m_busy   = 1'b0;
          spi_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 32'h0;
          done_t.push_back(ncyc);
          $display("[%0d] done miso=%08h", ncyc, spi_miso);
        end else begin
          m_cnt--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] d, input logic rd);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_read  = rd;
    for (int k = 0; k < 200 && !cmd_ready; k++) step();
    chk("push_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400 && !idle; k++) step();
    chk(tag, 64'(idle), 64'd1);
  endtask

  initial begin
    rst        = 1'b1;
    gap_cycles = 8'd2;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_read   = 1'b0;
    rsp_ready  = 1'b0;
    m_hold     = 1'b0;
    force_busy = 1'b0;
    m_lat      = 3;

    // Reset state
    step(); step();
    chk("rst_ready",     64'(cmd_ready),  64'd0);
    chk("rst_idle",      64'(idle),       64'd1);
    chk("rst_count",     64'(cmd_count),  64'd0);
    chk("rst_enable",    64'(spi_enable), 64'd0);
    chk("rst_spi_data",  64'(spi_mosi),   64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid),  64'd0);
    chk("rst_rsp_data",  64'(rsp_data),   64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Single write: enable one cycle after the push, response discarded
    miso_q.push_back(32'h12345678);
    push(32'hDEADBEEF, 1'b0);
    chk("w_count_after_push", 64'(cmd_count),  64'd1);
    chk("w_enable_not_yet",   64'(spi_enable), 64'd0);
    step();
    chk("w_enable",           64'(spi_enable), 64'd1);
    chk("w_spi_data",         64'(spi_mosi),   64'hDEADBEEF);
    step();
    chk("w_enable_pulse",     64'(spi_enable), 64'd0);
    chk("w_spi_data_hold",    64'(spi_mosi),   64'hDEADBEEF);
    wait_idle("w_idle");
    chk("w_rsp_valid",        64'(rsp_valid),  64'd0);
    chk("w_done_seen",        64'(done_t.size()), 64'd1);

    // Single read: response held until taken, cleared the cycle after
    miso_q.push_back(32'hCAFEF00D);
    push(32'h80000000, 1'b1);
    for (int k = 0; k < 100 && !rsp_valid; k++) step();
    chk("r_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("r_rsp_data",  64'(rsp_data),  64'hCAFEF00D);
    step(); step(); step();
    chk("r_rsp_hold_valid", 64'(rsp_valid), 64'd1);
    chk("r_rsp_hold_data",  64'(rsp_data),  64'hCAFEF00D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r_rsp_cleared", 64'(rsp_valid), 64'd0);
    wait_idle("r_idle");

    // FIFO full: four accepted while the master is busy, fifth waits for the first pop
    gap_cycles = 8'd1;
    force_busy = 1'b1;
    launch_q.delete();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 32'h100 + 32'(i);
      cmd_read  = 1'b0;
      chk("f_ready_fill", 64'(cmd_ready), 64'd1);
      step();
    end
    cmd_data = 32'h104;
    chk("f_full_ready", 64'(cmd_ready), 64'd0);
    chk("f_full_count", 64'(cmd_count), 64'd4);
    force_busy = 1'b0;
    step();
    chk("f_launch_enable",    64'(spi_enable), 64'd1);
    chk("f_ready_in_launch",  64'(cmd_ready),  64'd0);
    step();
    chk("f_ready_after_pop",  64'(cmd_ready),  64'd1);
    chk("f_count_after_pop",  64'(cmd_count),  64'd3);
    step();
    cmd_valid = 1'b0;
    chk("f_count_refill",     64'(cmd_count),  64'd4);
    wait_idle("f_idle");
    chk("f_launch_total", 64'(launch_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("f_order", 64'(launch_q[i]), 64'h100 + 64'(i));
    end

    // Response backpressure: second read stalls while the first response is held
    gap_cycles = 8'd0;
    launch_q.delete();
    miso_q.push_back(32'h11111111);
    miso_q.push_back(32'h22222222);
    push(32'h000000A1, 1'b1);
    push(32'h000000A2, 1'b1);
    for (int k = 0; k < 100 && !rsp_valid; k++) step();
    chk("bp_rsp1_valid", 64'(rsp_valid), 64'd1);
    chk("bp_rsp1_data",  64'(rsp_data),  64'h11111111);
    for (int k = 0; k < 8; k++) step();
    chk("bp_stalled_launches", 64'(launch_q.size()), 64'd1);
    chk("bp_stalled_count",    64'(cmd_count),       64'd1);
    chk("bp_stalled_data",     64'(rsp_data),        64'h11111111);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_rsp1_cleared", 64'(rsp_valid), 64'd0);
    for (int k = 0; k < 100 && !rsp_valid; k++) step();
    chk("bp_rsp2_valid",   64'(rsp_valid),       64'd1);
    chk("bp_rsp2_data",    64'(rsp_data),        64'h22222222);
    chk("bp_launches",     64'(launch_q.size()), 64'd2);
    chk("bp_second_mosi",  64'(launch_q[1]),     64'hA2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    wait_idle("bp_idle");

    // Gap timing: done-to-next-enable spacing is G+2 cycles
    gap_cycles = 8'd8;
    launch_t.delete();
    done_t.delete();
    push(32'h00000200, 1'b0);
    push(32'h00000201, 1'b0);
    wait_idle("g8_idle");
    chk("g8_spacing", 64'(launch_t[1] - done_t[0]), 64'd10);
    gap_cycles = 8'd0;
    launch_t.delete();
    done_t.delete();
    push(32'h00000300, 1'b0);
    push(32'h00000301, 1'b0);
    wait_idle("g0_idle");
    chk("g0_spacing", 64'(launch_t[1] - done_t[0]), 64'd2);

    // Reset in WAIT_DONE with three queued commands, then a stray done
    m_hold = 1'b1;
    launch_q.delete();
    done_t.delete();
    push(32'h000000B0, 1'b1);
    push(32'h000000B1, 1'b0);
    push(32'h000000B2, 1'b0);
    push(32'h000000B3, 1'b0);
    chk("rw_count_before", 64'(cmd_count), 64'd3);
    chk("rw_busy_before",  64'(idle),      64'd0);
    rst = 1'b1;
    step();
    chk("rw_count",     64'(cmd_count),  64'd0);
    chk("rw_rsp_valid", 64'(rsp_valid),  64'd0);
    chk("rw_idle",      64'(idle),       64'd1);
    chk("rw_spi_data",  64'(spi_mosi),   64'd0);
    chk("rw_ready",     64'(cmd_ready),  64'd0);
    rst = 1'b0;
    miso_q.push_back(32'hDEAD0001);
    m_hold = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("stray_done_seen",    64'(done_t.size()),   64'd1);
    chk("stray_no_response",  64'(rsp_valid),       64'd0);
    chk("stray_no_launch",    64'(launch_q.size()), 64'd1);
    chk("stray_idle",         64'(idle),            64'd1);

    // Normal operation resumes after reset
    push(32'h000000C0, 1'b0);
    wait_idle("resume_idle");
    chk("resume_launches", 64'(launch_q.size()), 64'd2);
    chk("resume_mosi",     64'(launch_q[1]),     64'hC0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
